kf_step_sched: RTL

Frame-level sequencer for the fixed-point Kalman filter core. It accepts one measurement per frame, then steps the stage blocks in order with one-cycle start pulses and waits for each done: the Q-update stage (diagonal process noise from the state difference), predict, gain and update. It owns the current and previous state registers that feed the Q-update stage, commits the posterior state at the end of each frame, and reports frame completion and stalls.

---
 rtl/kf_step_sched.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/kf_step_sched.sv
// ---------------------------------------------------------------------------
// kf_step_sched -- frame-level sequencer for the fixed-point Kalman filter.
//
// Accepts one measurement per frame. It then steps the stage blocks in the
// order Q-update -> predict -> gain -> update. Each stage gets a one-cycle
// start pulse, and the sequencer waits for that stage's done pulse. The block
// owns the current/previous state registers that feed the Q-update stage. It
// commits the posterior state at the end of every frame.
//
// The very first frame after reset has no previous state to difference
// against. That frame skips the Q-update stage, and downstream Q keeps its
// reset value.
//
// Optional build macro:
//   KF_SEQ_WATCHDOG_EN  per-stage cycle watchdog. A stage that has not
//                       signalled done within TIMEOUT cycles sends the
//                       sequencer to FAULT with err=1. clr_err returns it to
//                       IDLE. Without the macro, stages wait indefinitely,
//                       FAULT is unreachable and err stays 0.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   meas_valid / meas_ready          measurement handshake (accepted in IDLE)
//   z0_in, z1_in -> z0, z1           measurement, latched for the whole frame
//   q/pred/gain/upd_start            one-cycle stage start pulses
//   q/pred/gain/upd_done             stage completion pulses
//   x00_upd, x01_upd                 posterior state from the update stage
//   x00_now, x01_now                 current state
//   x00_prev, x01_prev               previous-frame state
//   busy                             frame in progress (any state but IDLE)
//   frame_done                       one-cycle pulse during COMMIT
//   frame_cnt                        committed frames, wraps
//   err / clr_err                    sticky stage-timeout fault / clear
// ---------------------------------------------------------------------------
module kf_step_sched #(
  parameter int N       = 20,
  parameter int FRAC    = 10,
  parameter int FRAME_W = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                meas_valid,
  output logic                meas_ready,
  input  logic signed [N-1:0] z0_in,
  input  logic signed [N-1:0] z1_in,
  output logic signed [N-1:0] z0,
  output logic signed [N-1:0] z1,
  output logic                q_start,
  output logic                pred_start,
  output logic                gain_start,
  output logic                upd_start,
  input  logic                q_done,
  input  logic                pred_done,
  input  logic                gain_done,
  input  logic                upd_done,
  input  logic signed [N-1:0] x00_upd,
  input  logic signed [N-1:0] x01_upd,
  output logic signed [N-1:0] x00_now,
  output logic signed [N-1:0] x01_now,
  output logic signed [N-1:0] x00_prev,
  output logic signed [N-1:0] x01_prev,
  output logic                busy,
  output logic                frame_done,
  output logic [FRAME_W-1:0]  frame_cnt,
  output logic                err,
  input  logic                clr_err
);

  // FRAC only documents the Q format of the words passed through. A format
  // with no integer bit, or a zero watchdog limit, is not a meaningful
  // configuration. Such a configuration elaborates this marker block, which
  // shows up in the design hierarchy.
  generate
    if (FRAC >= N || TIMEOUT < 1) begin : g_bad_cfg
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_QCALC  = 3'd1,
    S_PRED   = 3'd2,
    S_GAIN   = 3'd3,
    S_UPD    = 3'd4,
    S_COMMIT = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t              st_r;
  state_t              next_st_s;
  logic                stage_done_s;
  logic                first_r;
  logic                meas_ready_r;
  logic                busy_r;
  logic                q_start_r;
  logic                pred_start_r;
  logic                gain_start_r;
  logic                upd_start_r;
  logic                frame_done_r;
  logic                err_r;
  logic [FRAME_W-1:0]  frame_cnt_r;
  logic signed [N-1:0] z0_r;
  logic signed [N-1:0] z1_r;
  logic signed [N-1:0] x00_now_r;
  logic signed [N-1:0] x01_now_r;
  logic signed [N-1:0] x00_prev_r;
  logic signed [N-1:0] x01_prev_r;

`ifdef KF_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  // The counter reads 0 in a stage's first cycle. The stage therefore faults
  // at the end of its TIMEOUT-th cycle if no done was seen by then.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt_r;
`endif

  // Only the done of the stage currently active can advance the sequence.
  // All other done inputs are ignored.
  always_comb begin
    stage_done_s = 1'b0;
    next_st_s    = st_r;
    case (st_r)
      S_QCALC: begin
        stage_done_s = q_done;
        next_st_s    = S_PRED;
      end
      S_PRED: begin
        stage_done_s = pred_done;
        next_st_s    = S_GAIN;
      end
      S_GAIN: begin
        stage_done_s = gain_done;
        next_st_s    = S_UPD;
      end
      S_UPD: begin
        stage_done_s = upd_done;
        next_st_s    = S_COMMIT;
      end
      default: begin
        stage_done_s = 1'b0;
        next_st_s    = st_r;
      end
    endcase
  end

  // Sequencer FSM with all outputs and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r         <= S_IDLE;
      first_r      <= 1'b1;
      meas_ready_r <= 1'b1;
      busy_r       <= 1'b0;
      q_start_r    <= 1'b0;
      pred_start_r <= 1'b0;
      gain_start_r <= 1'b0;
      upd_start_r  <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
      frame_cnt_r  <= {FRAME_W{1'b0}};
      z0_r         <= {N{1'b0}};
      z1_r         <= {N{1'b0}};
      x00_now_r    <= {N{1'b0}};
      x01_now_r    <= {N{1'b0}};
      x00_prev_r   <= {N{1'b0}};
      x01_prev_r   <= {N{1'b0}};
`ifdef KF_SEQ_WATCHDOG_EN
      wd_cnt_r     <= {WD_W{1'b0}};
`endif
    end else begin
      // Pulse outputs last one cycle unless re-armed below.
      q_start_r    <= 1'b0;
      pred_start_r <= 1'b0;
      gain_start_r <= 1'b0;
      upd_start_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (st_r)
        S_IDLE: begin
          if (meas_valid) begin
            z0_r         <= z0_in;
            z1_r         <= z1_in;
            meas_ready_r <= 1'b0;
            busy_r       <= 1'b1;
`ifdef KF_SEQ_WATCHDOG_EN
            wd_cnt_r     <= {WD_W{1'b0}};
`endif
            if (first_r) begin
              st_r         <= S_PRED;
              pred_start_r <= 1'b1;
            end else begin
              st_r      <= S_QCALC;
              q_start_r <= 1'b1;
            end
          end
        end
        S_QCALC, S_PRED, S_GAIN, S_UPD: begin
          if (stage_done_s) begin
            st_r         <= next_st_s;
            pred_start_r <= (next_st_s == S_PRED);
            gain_start_r <= (next_st_s == S_GAIN);
            upd_start_r  <= (next_st_s == S_UPD);
            frame_done_r <= (next_st_s == S_COMMIT);
`ifdef KF_SEQ_WATCHDOG_EN
            wd_cnt_r     <= {WD_W{1'b0}};
          end else if (wd_cnt_r == WD_LAST) begin
            st_r  <= S_FAULT;
            err_r <= 1'b1;
          end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
`endif
          end
        end
        S_COMMIT: begin
          // Old register values on the right-hand side: prev takes the
          // pre-commit current state.
          x00_prev_r   <= x00_now_r;
          x01_prev_r   <= x01_now_r;
          x00_now_r    <= x00_upd;
          x01_now_r    <= x01_upd;
          frame_cnt_r  <= frame_cnt_r + FRAME_W'(1);
          first_r      <= 1'b0;
          st_r         <= S_IDLE;
          meas_ready_r <= 1'b1;
          busy_r       <= 1'b0;
        end
        S_FAULT: begin
          // Only reachable in the watchdog build. State registers, the
          // frame counter and the first flag are left untouched.
          if (clr_err) begin
            st_r         <= S_IDLE;
            err_r        <= 1'b0;
            meas_ready_r <= 1'b1;
            busy_r       <= 1'b0;
          end
        end
        default: begin
          st_r         <= S_IDLE;
          err_r        <= 1'b0;
          meas_ready_r <= 1'b1;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign meas_ready = meas_ready_r;
  assign busy       = busy_r;
  assign q_start    = q_start_r;
  assign pred_start = pred_start_r;
  assign gain_start = gain_start_r;
  assign upd_start  = upd_start_r;
  assign frame_done = frame_done_r;
  assign frame_cnt  = frame_cnt_r;
  assign err        = err_r;
  assign z0         = z0_r;
  assign z1         = z1_r;
  assign x00_now    = x00_now_r;
  assign x01_now    = x01_now_r;
  assign x00_prev   = x00_prev_r;
  assign x01_prev   = x01_prev_r;

endmodule
